mac_exec_sequencer: RTL and testbench
=====================================

// Module: mac_exec_sequencer
// PURPOSE
//  Execution-phase sequencer downstream of the memory-load controller.
//  - After the A/B FIFO bank is filled, drains ROWS A FIFOs and the B FIFO into MAC8 for K dot-product steps.
//  - Captures the ROWS accumulator outputs and exposes them through an indexed result read port.
//  - Replaces the hand-driven Clr/En/rden sequencing used in bring-up benches.
// PARAMETERS
//  DATA_WIDTH    8  operand width; accumulator width ACC_W = 3*DATA_WIDTH (localparam)
//  ROWS          8  number of A FIFOs / MAC lanes
//  K             8  vector length = FIFO reads per lane per run (K >= 2)
//  DRAIN_CYCLES  2  idle cycles after the last En before capture (>= 1)
// PORTS
//  clk        in   1             clock
//  rst_n      in   1             synchronous active-low reset
//  go         in   1             start request (level or pulse); normally controller done
//  a_empty    in   ROWS          A FIFO empty flags
//  b_empty    in   1             B FIFO empty flag
//  a_rden     out  ROWS          A FIFO read enables (all bits identical)
//  b_rden     out  1             B FIFO read enable
//  mac_clr    out  1             MAC8 Clr_in
//  mac_en     out  1             MAC8 En_in
//  c_in       in   ROWS*ACC_W    MAC8 c_out, flattened; lane i = c_in[i*ACC_W +: ACC_W]
//  res_idx    in   $clog2(ROWS)  result lane select
//  res_data   out  ACC_W         captured result for res_idx, registered (1-cycle latency)
//  busy       out  1             high in every state except IDLE
//  done       out  1             1-cycle pulse on CAPTURE
//  underflow  out  1             sticky: a read was issued while a FIFO was empty
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; result regs 0; counters 0; underflow 0.
//  FSM: IDLE -> PRELOAD -> RUN -> DRAIN -> CAPTURE -> IDLE.
//  IDLE:    all ctrl outputs 0. Leave when go && ~|a_empty && ~b_empty.
//           go with any FIFO empty: stay IDLE (wait; no error).
//           Taking go clears underflow.
//  PRELOAD: 1 cycle; mac_clr=1, a_rden='1, b_rden=1, mac_en=0.
//  RUN:     cnt 0..K-1, one per cycle; mac_en=1.
//           a_rden/b_rden=1 only while cnt < K-1, giving exactly K reads per FIFO (incl. preload).
//           mac_clr=0. Leave after cnt==K-1.
//  DRAIN:   DRAIN_CYCLES cycles; all ctrl outputs 0.
//  CAPTURE: 1 cycle; res[i] <= c_in lane i for all lanes; done=1; next state IDLE.
//  underflow set on any cycle where (|a_rden && |(a_rden & a_empty)) || (b_rden && b_empty).
//           FSM does not abort on underflow; run completes.
//  res_data <= res[res_idx] every cycle; updates the cycle after CAPTURE for a held res_idx.
//  go while busy: ignored. go held high through CAPTURE: a new run starts from IDLE on the next cycle.
//  Total latency go-accept -> done: 1 + K + DRAIN_CYCLES + 1 cycles (default 12).
//  Reset mid-run: immediate return to IDLE; outputs 0; results cleared.
//  Results hold until the next CAPTURE.
// CONFIGURATION
//  EXEC_PERF_CNT_EN defined:
//   - adds output perf_cycles [15:0] counting cycles from go-accept through CAPTURE inclusive.
//   - cleared on go-accept; holds after done; saturates at 16'hFFFF.
//   - default value 12.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Fill A FIFO lane i with i+1 (x8) and B with 1 (x8), pulse go ->
//     res lane i = 8*(i+1), done pulse 12 cycles after accept.
//  2. go with b_empty=1 -> stays IDLE, busy=0, no rden; deassert b_empty -> run starts the next cycle.
//  3. Count rden cycles in one run -> exactly 8 per FIFO; mac_clr only in PRELOAD; mac_en high exactly 8 cycles.
//  4. Force a_empty[3]=1 during RUN -> underflow=1 sticky, done still pulses; next go clears underflow.
//  5. Assert rst_n=0 in RUN cnt=4 -> next cycle all outputs 0, res_data 0, busy=0.
//  6. EXEC_PERF_CNT_EN defined, default params -> perf_cycles=12 after done; sweep res_idx 0..7 -> matching lanes, 1-cycle latency.

Source files
------------

// File: rtl/mac_exec_sequencer.sv
// Execution sequencer: drains the A/B FIFO bank into MAC8 and captures lane results.
// Optional EXEC_PERF_CNT_EN adds a perf_cycles run-length counter.
module mac_exec_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int ROWS         = 8,
  parameter int K            = 8,
  parameter int DRAIN_CYCLES = 2,
  localparam int ACC_W       = 3 * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  input  logic [ROWS-1:0]         a_empty,
  input  logic                    b_empty,
  output logic [ROWS-1:0]         a_rden,
  output logic                    b_rden,
  output logic                    mac_clr,
  output logic                    mac_en,
  input  logic [ROWS*ACC_W-1:0]   c_in,
  input  logic [$clog2(ROWS)-1:0] res_idx,
  output logic [ACC_W-1:0]        res_data,
  output logic                    busy,
  output logic                    done,
  output logic                    underflow
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [15:0]             perf_cycles
`endif
);

  localparam int CMAX = (K > DRAIN_CYCLES) ? K : DRAIN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    RUN,
    DRAIN,
    CAPTURE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [ACC_W-1:0] res [ROWS];
  logic            start;
  logic            uf_hit;

  assign start  = go && !(|a_empty) && !b_empty;
  assign uf_hit = (|(a_rden & a_empty)) || (b_rden && b_empty);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_rden    <= '0;
      b_rden    <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (uf_hit) underflow <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= PRELOAD;
            busy      <= 1'b1;
            mac_clr   <= 1'b1;
            a_rden    <= '1;
            b_rden    <= 1'b1;
            underflow <= 1'b0;
          end
        end
        PRELOAD: begin
          state   <= RUN;
          cnt     <= '0;
          mac_clr <= 1'b0;
          mac_en  <= 1'b1;
          a_rden  <= '1;
          b_rden  <= 1'b1;
        end
        RUN: begin
          if (cnt == CW'(K - 1)) begin
            state  <= DRAIN;
            cnt    <= '0;
            mac_en <= 1'b0;
            a_rden <= '0;
            b_rden <= 1'b0;
          end else begin
            // preload already took one read, so stop one step early
            cnt    <= cnt + CW'(1);
            a_rden <= {ROWS{cnt < CW'(K - 2)}};
            b_rden <= cnt < CW'(K - 2);
          end
        end
        DRAIN: begin
          if (cnt == CW'(DRAIN_CYCLES - 1)) begin
            state <= CAPTURE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAPTURE: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) res[i] <= '0;
      res_data <= '0;
    end else begin
      res_data <= res[res_idx];
      if (state == CAPTURE) begin
        for (int i = 0; i < ROWS; i++) begin
          res[i] <= c_in[i*ACC_W +: ACC_W];
        end
      end
    end
  end

`ifdef EXEC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != 16'hFFFF) begin
      perf_cycles <= perf_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_exec_sequencer.sv
// Bench for mac_exec_sequencer: run-timeline reference model, directed cases
// plus randomized go/empty/reset traffic.
module tb_mac_exec_sequencer;

  localparam int DW    = 8;
  localparam int ROWS  = 8;
  localparam int K     = 8;
  localparam int DR    = 2;
  localparam int ACC_W = 3 * DW;
  localparam int TOT   = 1 + K + DR + 1;

  logic                    clk;
  logic                    rst_n;
  logic                    go;
  logic [ROWS-1:0]         a_empty;
  logic                    b_empty;
  logic [ROWS-1:0]         a_rden;
  logic                    b_rden;
  logic                    mac_clr;
  logic                    mac_en;
  logic [ROWS*ACC_W-1:0]   c_in;
  logic [$clog2(ROWS)-1:0] res_idx;
  logic [ACC_W-1:0]        res_data;
  logic                    busy;
  logic                    done;
  logic                    underflow;
`ifdef EXEC_PERF_CNT_EN
  logic [15:0]             perf_cycles;
`endif

  int tests = 0;
  int fails = 0;

  mac_exec_sequencer #(
    .DATA_WIDTH  (DW),
    .ROWS        (ROWS),
    .K           (K),
    .DRAIN_CYCLES(DR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .a_empty  (a_empty),
    .b_empty  (b_empty),
    .a_rden   (a_rden),
    .b_rden   (b_rden),
    .mac_clr  (mac_clr),
    .mac_en   (mac_en),
    .c_in     (c_in),
    .res_idx  (res_idx),
    .res_data (res_data),
    .busy     (busy),
    .done     (done),
    .underflow(underflow)
`ifdef EXEC_PERF_CNT_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // MAC8 stand-in: lane i sees A=i+1, B=1 every read
  logic                  mac_mode;
  logic [ACC_W-1:0]      acc [ROWS];
  logic [ROWS*ACC_W-1:0] acc_flat;
  logic [ROWS*ACC_W-1:0] rnd_c;

  always @(posedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (!rst_n || mac_clr) acc[i] <= '0;
      else if (mac_en) acc[i] <= acc[i] + ACC_W'(i + 1);
    end
  end

  always_comb begin
    acc_flat = '0;
    for (int i = 0; i < ROWS; i++) acc_flat[i*ACC_W +: ACC_W] = acc[i];
  end

  assign c_in = mac_mode ? acc_flat : rnd_c;

  // Reference model: t = cycles since go-accept (0 = idle)
  int               t = 0;
  logic             u_m = 1'b0;
  logic [ACC_W-1:0] rd_m = '0;
  logic [15:0]      perf_m = '0;
  logic [ACC_W-1:0] res_m [ROWS];
  int               n_ra = 0, n_rb = 0, n_en = 0, n_clr = 0;

  always @(negedge clk) begin : mdl
    logic            e_rd;
    logic [ROWS-1:0] e_a;
    logic [ACC_W-1:0] rd_new;
    e_rd = (t >= 1) && (t <= K);
    e_a  = e_rd ? '1 : '0;
    chk("busy", 32'(busy), 32'(t != 0));
    chk("done", 32'(done), 32'(t == TOT));
    chk("mac_clr", 32'(mac_clr), 32'(t == 1));
    chk("mac_en", 32'(mac_en), 32'((t >= 2) && (t <= K + 1)));
    chk("a_rden", 32'(a_rden), 32'(e_a));
    chk("b_rden", 32'(b_rden), 32'(e_rd));
    chk("underflow", 32'(underflow), 32'(u_m));
    chk("res_data", 32'(res_data), 32'(rd_m));
`ifdef EXEC_PERF_CNT_EN
    chk("perf_cycles", 32'(perf_cycles), 32'(perf_m));
`endif
    if (t != 0) begin
      n_ra  += int'(a_rden[ROWS-1]);
      n_rb  += int'(b_rden);
      n_en  += int'(mac_en);
      n_clr += int'(mac_clr);
    end else begin
      n_ra = 0; n_rb = 0; n_en = 0; n_clr = 0;
    end
    if (t == TOT) begin
      chk("run_a_reads", 32'(n_ra), 32'(K));
      chk("run_b_reads", 32'(n_rb), 32'(K));
      chk("run_en_cycles", 32'(n_en), 32'(K));
      chk("run_clr_cycles", 32'(n_clr), 32'(1));
    end
    if (!rst_n) begin
      t = 0; u_m = 1'b0; rd_m = '0; perf_m = '0;
      for (int i = 0; i < ROWS; i++) res_m[i] = '0;
    end else begin
      rd_new = res_m[res_idx];
      if (t == 0) begin
        if (go && !(|a_empty) && !b_empty) begin
          t = 1; u_m = 1'b0; perf_m = '0;
        end
      end else begin
        if (e_rd && ((|a_empty) || b_empty)) u_m = 1'b1;
        if (perf_m != 16'hFFFF) perf_m = perf_m + 16'd1;
        if (t == TOT) begin
          for (int i = 0; i < ROWS; i++) res_m[i] = c_in[i*ACC_W +: ACC_W];
          t = 0;
        end else begin
          t = t + 1;
        end
      end
      rd_m = rd_new;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    for (int i = 0; i < ROWS; i++) rnd_c[i*ACC_W +: ACC_W] = ACC_W'($urandom);
  endtask

  task automatic wait_t(input int tgt);
    int n;
    n = 0;
    while (t != tgt && n < 40) begin
      tick;
      n++;
    end
    if (t != tgt) chk("wait_timeout", 32'(t), 32'(tgt));
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; a_empty = '0; b_empty = 1'b0;
    res_idx = '0; rnd_c = '0; mac_mode = 1'b1;
    repeat (3) tick;
    rst_n = 1'b1;

    // lane i accumulates K*(i+1)
    go = 1'b1;
    tick;
    go = 1'b0;
    wait_t(0);
    for (int i = 0; i < ROWS; i++) begin
      res_idx = ($clog2(ROWS))'(i);
      tick;
      chk("lane_sum", 32'(res_data), 32'(K * (i + 1)));
    end

    // go with B empty must wait
    mac_mode = 1'b0;
    b_empty = 1'b1;
    go = 1'b1;
    repeat (5) tick;
    chk("wait_busy", 32'(busy), 32'(0));
    b_empty = 1'b0;
    tick;
    tick;
    chk("start_busy", 32'(busy), 32'(1));
    go = 1'b0;
    wait_t(0);

    // underflow is sticky through the run, then cleared by the next go
    go = 1'b1;
    tick;
    go = 1'b0;
    wait_t(4);
    a_empty[3] = 1'b1;
    tick;
    a_empty = '0;
    wait_t(0);
    chk("uf_sticky", 32'(underflow), 32'(1));
    go = 1'b1;
    tick;
    go = 1'b0;
    tick;
    chk("uf_clear", 32'(underflow), 32'(0));
    wait_t(0);

    // reset in RUN cnt=4
    go = 1'b1;
    tick;
    go = 1'b0;
    wait_t(6);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_en", 32'(mac_en), 32'(0));
    res_idx = 2;
    tick;
    chk("rst_res", 32'(res_data), 32'(0));

    for (int c = 0; c < 600; c++) begin
      go      = ($urandom_range(0, 3) != 0);
      b_empty = ($urandom_range(0, 9) == 0);
      a_empty = ($urandom_range(0, 7) == 0) ?
                (ROWS'(1) << $urandom_range(0, ROWS - 1)) : '0;
      res_idx = ($clog2(ROWS))'($urandom);
      rst_n   = ($urandom_range(0, 299) != 0);
      tick;
    end
    rst_n = 1'b1; go = 1'b0; a_empty = '0; b_empty = 1'b0;
    wait_t(0);

`ifdef EXEC_PERF_CNT_EN
    go = 1'b1;
    tick;
    go = 1'b0;
    wait_t(0);
    tick;
    chk("perf_run", 32'(perf_cycles), 32'(TOT));
`endif
    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
